// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit:
// FSM states, iteration counts and the radix-4 Booth digit recoder.
package mdu_pkg;

  localparam int          MULT_STEPS = 16;
  localparam int          DIV_STEPS  = 32;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  typedef enum logic [2:0] {ZERO, PLUS1, PLUS2, MINUS1, MINUS2} booth_e;

  // Maps {q[1], q[0], q[-1]} onto a signed multiple of the multiplicand.
  function automatic booth_e booth_recode(input logic [2:0] bits);
    booth_e digit;
    case (bits)
      3'b001, 3'b010: digit = PLUS1;
      3'b011:         digit = PLUS2;
      3'b100:         digit = MINUS2;
      3'b101, 3'b110: digit = MINUS1;
      default:        digit = ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Iteration down-counter: loads a step count on start and flags the cycle
// in which an enabled count has reached zero.
module multdiv_counter (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [5:0] count_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 6'd1;
    end
  end

  assign done = en && (count_q == '0);

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (radix-4 Booth) and divide (non-restoring)
// for the execute stage; result and exception hold until the next completion.
module multdiv_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MULT_STEPS = mdu_pkg::MULT_STEPS,
  parameter int DIV_STEPS  = mdu_pkg::DIV_STEPS
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
);

  state_e      state_q, state_d;
  logic [33:0] acc_q, acc_d;        // Booth accumulator / division remainder
  logic [31:0] q_q, q_d;            // multiplier / quotient shift register
  logic        extra_q, extra_d;    // Booth q[-1] bit
  logic [31:0] m_q, m_d;            // multiplicand / divisor magnitude
  logic        neg_q, neg_d;
  logic        div0_q, div0_d;
  logic        ovf_q, ovf_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;

  logic        cnt_load;
  logic [5:0]  cnt_load_val;
  logic        cnt_en;
  logic        cnt_done;

  booth_e      booth;
  logic [33:0] m_ext, addend, sum;
  logic [33:0] shifted, rem_new;
  logic [31:0] abs_a, abs_b;

  multdiv_counter u_counter (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .done     (cnt_done)
  );

  assign cnt_en = (state_q == MUL) || (state_q == DIV);

  // Two's-complement magnitudes; INT_MIN maps to unsigned 2^31.
  assign abs_a = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
  assign abs_b = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

  always_comb begin
    // NOTE: every combinational output gets a default before the case so
    // that no path leaves a signal unassigned and infers a latch.
    state_d      = state_q;
    acc_d        = acc_q;
    q_d          = q_q;
    extra_d      = extra_q;
    m_d          = m_q;
    neg_d        = neg_q;
    div0_d       = div0_q;
    ovf_d        = ovf_q;
    result_d     = result_q;
    exc_d        = exc_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    booth        = booth_recode({q_q[1:0], extra_q});
    m_ext        = {{2{m_q[31]}}, m_q};
    addend       = '0;
    sum          = '0;
    shifted      = {acc_q[32:0], q_q[31]};
    rem_new      = '0;

    unique case (state_q)
      IDLE: begin
        if (ctrl_MULT) begin
          state_d      = MUL;
          cnt_load     = 1'b1;
          cnt_load_val = 6'(MULT_STEPS);
          acc_d        = '0;
          q_d          = data_operandB;
          extra_d      = 1'b0;
          m_d          = data_operandA;
        end else if (ctrl_DIV) begin
          state_d      = DIV;
          cnt_load     = 1'b1;
          cnt_load_val = 6'(DIV_STEPS);
          acc_d        = '0;
          q_d          = abs_a;
          m_d          = abs_b;
          neg_d        = data_operandA[31] ^ data_operandB[31];
          div0_d       = (data_operandB == '0);
          ovf_d        = (data_operandA == INT_MIN) && (data_operandB == '1);
        end
      end

      MUL: begin
        if (cnt_done) begin
          state_d  = DONE;
          result_d = q_q;
          exc_d    = (acc_q[31:0] != {32{q_q[31]}});
        end else begin
          unique case (booth)
            PLUS1:   addend = m_ext;
            PLUS2:   addend = {m_ext[32:0], 1'b0};
            MINUS1:  addend = 34'd0 - m_ext;
            MINUS2:  addend = 34'd0 - {m_ext[32:0], 1'b0};
            default: addend = '0;
          endcase
          // Two guard bits keep +/-2M exact before the arithmetic shift by 2.
          sum     = acc_q + addend;
          acc_d   = {{2{sum[33]}}, sum[33:2]};
          q_d     = {sum[1:0], q_q[31:2]};
          extra_d = q_q[1];
        end
      end

      DIV: begin
        if (cnt_done) begin
          state_d = DONE;
          if (div0_q) begin
            result_d = '0;
            exc_d    = 1'b1;
          end else if (ovf_q) begin
            result_d = INT_MIN;
            exc_d    = 1'b1;
          end else begin
            result_d = neg_q ? (32'd0 - q_q) : q_q;
            exc_d    = 1'b0;
          end
        end else begin
          rem_new = acc_q[33] ? (shifted + {2'b00, m_q})
                              : (shifted - {2'b00, m_q});
          acc_d   = rem_new;
          q_d     = {q_q[30:0], ~rem_new[33]};
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  // NOTE: datapath registers carry no reset; they are always reloaded on
  // start before being read, so resetting them would only add logic.
  always_ff @(posedge clk) begin
    acc_q   <= acc_d;
    q_q     <= q_d;
    extra_q <= extra_d;
    m_q     <= m_d;
    neg_q   <= neg_d;
    div0_q  <= div0_d;
    ovf_q   <= ovf_d;
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign data_busy      = (state_q == MUL) || (state_q == DIV);

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: vector table through a scoreboard,
// latency/busy checks, and hand-written start-collision and clear sequences.
module tb_multdiv_unit;

  typedef enum int {OP_MUL, OP_DIV, OP_BOTH} op_e;

  typedef struct {
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, data_busy;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  multdiv_unit dut (
    .clk            (clk),
    .clr            (clr),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every RDY pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (data_resultRDY === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rdy: got RDY with result %h, expected no RDY", data_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_result", data_result, e.res);
        check("sb_exception", 32'(data_exception), 32'(e.exc));
      end
    end
  end

  // Issues one operation at edge E0 and checks latency, busy width and hold.
  // poke_n >= 0 pulses ctrl_DIV so that it is sampled at edge E0+poke_n.
  task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic exc, input int poke_n);
    int   n;
    int   busy_cnt;
    int   exp_lat;
    bit   seen;
    exp_t e;
    exp_lat = (op == OP_DIV) ? 33 : 17;
    @(negedge clk);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = (op != OP_DIV);
    ctrl_DIV      = (op != OP_MUL);
    e.res = res;
    e.exc = exc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    n        = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (n < 60) begin
      @(negedge clk);
      ctrl_DIV = (poke_n >= 0) && (n == poke_n - 1);
      if (data_resultRDY === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (data_busy === 1'b1) busy_cnt++;
      @(posedge clk);
      n++;
    end
    ctrl_DIV = 1'b0;
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no RDY within %0d cycles, expected RDY at %0d", n, exp_lat);
    end else begin
      check("latency", 32'(n), 32'(exp_lat));
      check("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
      check("busy_in_done", 32'(data_busy), 32'd0);
      @(negedge clk);
      check("rdy_one_cycle", 32'(data_resultRDY), 32'd0);
      check("result_hold", data_result, res);
    end
  endtask

  function automatic exp_t model(input op_e op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    if (op == OP_DIV) begin
      if (b == 32'd0) begin
        e.res = 32'd0;
        e.exc = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.res = 32'h8000_0000;
        e.exc = 1'b1;
      end else begin
        e.res = 32'($signed(a) / $signed(b));
        e.exc = 1'b0;
      end
    end else begin
      p     = 64'($signed(64'($signed(a))) * $signed(64'($signed(b))));
      e.res = p[31:0];
      e.exc = (p[63:32] != {32{p[31]}});
    end
    return e;
  endfunction

  vec_t vecs [21];

  initial begin
    vecs[0]  = '{OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
    vecs[2]  = '{OP_MUL, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0};
    vecs[3]  = '{OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[4]  = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[5]  = '{OP_MUL, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
    vecs[6]  = '{OP_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[7]  = '{OP_MUL, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[8]  = '{OP_MUL, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b1};
    vecs[9]  = '{OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    vecs[10] = '{OP_DIV, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
    vecs[11] = '{OP_DIV, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[12] = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[13] = '{OP_DIV, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0};
    vecs[14] = '{OP_DIV, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 1'b0};
    vecs[15] = '{OP_DIV, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[16] = '{OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 1'b0};
    vecs[17] = '{OP_DIV, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 1'b0};
    vecs[18] = '{OP_DIV, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[19] = '{OP_DIV, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 1'b0};
    vecs[20] = '{OP_DIV, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};

    clr           = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_result", data_result, 32'd0);
    check("reset_exception", 32'(data_exception), 32'd0);
    check("reset_rdy", 32'(data_resultRDY), 32'd0);
    check("reset_busy", 32'(data_busy), 32'd0);
    clr = 1'b0;

    for (int i = 0; i < 21; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc, -1);
    end

    for (int i = 0; i < 12; i++) begin
      op_e         op;
      logic [31:0] a, b;
      exp_t        e;
      op = (i % 2 == 0) ? OP_MUL : OP_DIV;
      a  = $urandom;
      b  = (i % 4 == 1) ? ($urandom & 32'h0000_0FFF) : $urandom;
      if (i % 3 == 0) a = a >>> 12;
      e  = model(op, a, b);
      run_op(op, a, b, e.res, e.exc, -1);
    end

    // Both starts together: multiply wins. A later DIV pulse is ignored.
    run_op(OP_BOTH, 32'd6, 32'd3, 32'd18, 1'b0, 5);
    repeat (40) @(negedge clk);
    check("idle_after_ignored_div", 32'(data_busy), 32'd0);
    check("idle_result_hold", data_result, 32'd18);

    // Clear in the middle of a divide: abandoned, no RDY.
    @(negedge clk);
    data_operandA = 32'd1000;
    data_operandB = 32'd7;
    ctrl_DIV      = 1'b1;
    @(posedge clk);
    #1;
    ctrl_DIV = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("busy_before_clr", 32'(data_busy), 32'd1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("clr_result", data_result, 32'd0);
    check("clr_exception", 32'(data_exception), 32'd0);
    check("clr_rdy", 32'(data_resultRDY), 32'd0);
    check("clr_busy", 32'(data_busy), 32'd0);
    repeat (50) @(negedge clk);
    check("clr_stays_idle", 32'(data_busy), 32'd0);

    run_op(OP_MUL, 32'd3, 32'd4, 32'd12, 1'b0, -1);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
